// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack handshake, 2-entry IF/ID queue, branch redirect.
// Optional FETCH_PERF_EN adds perf_fetched/perf_stall/perf_flush counters.
module if_fetch_unit #(
  parameter int unsigned         PC_WIDTH    = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned         INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [PC_WIDTH-1:0]    id_pc,
  output logic [INSTR_WIDTH-1:0] id_instr,
  output logic [6:0]             id_opcode
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_stall,
  output logic [31:0]            perf_flush
`endif
);

  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_KILL} state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    kill_addr_q, kill_addr_d;
  logic [1:0]             count_q, count_d;
  logic [PC_WIDTH-1:0]    head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
  logic [INSTR_WIDTH-1:0] head_instr_q, head_instr_d, tail_instr_q, tail_instr_d;

  logic ack_acc, push, pop;
  logic unused_tgt_lsbs;

  assign unused_tgt_lsbs = ^branch_target[1:0];

  assign imem_req  = (state_q == S_KILL) || ((state_q == S_FETCH) && (count_q != 2'd2));
  // While draining a wrong-path request the address must stay on the old PC.
  assign imem_addr = (state_q == S_KILL) ? kill_addr_q : pc_q;
  assign id_valid  = (count_q != 2'd0);
  assign id_pc     = head_pc_q;
  assign id_instr  = head_instr_q;
  assign id_opcode = head_instr_q[6:0];

  assign ack_acc = imem_ack && imem_req;
  assign pop     = id_valid && id_ready;
  assign push    = ack_acc && (state_q == S_FETCH);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_addr_d  = kill_addr_q;
    count_d      = count_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    tail_pc_d    = tail_pc_q;
    tail_instr_d = tail_instr_q;

    if (branch_taken) begin
      count_d = 2'd0;
      pc_d    = {branch_target[PC_WIDTH-1:2], 2'b00};
      if (state_q == S_KILL) begin
        state_d = ack_acc ? S_FETCH : S_KILL;
      end else if (imem_req && !ack_acc) begin
        state_d     = S_KILL;
        kill_addr_d = pc_q;
      end else begin
        state_d = S_FETCH;
      end
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_FETCH;
        S_KILL:  if (ack_acc) state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase

      if (push) pc_d = pc_q + PC_WIDTH'(4);

      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_pc_d    = pc_q;
            head_instr_d = imem_rdata;
          end else begin
            tail_pc_d    = pc_q;
            tail_instr_d = imem_rdata;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_pc_d    = tail_pc_q;
          head_instr_d = tail_instr_q;
          count_d      = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            head_pc_d    = tail_pc_q;
            head_instr_d = tail_instr_q;
            tail_pc_d    = pc_q;
            tail_instr_d = imem_rdata;
          end else begin
            head_pc_d    = pc_q;
            head_instr_d = imem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      kill_addr_q  <= RESET_PC;
      count_q      <= 2'd0;
      head_pc_q    <= '0;
      head_instr_q <= NOP;
      tail_pc_q    <= '0;
      tail_instr_q <= NOP;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_addr_q  <= kill_addr_d;
      count_q      <= count_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      tail_pc_q    <= tail_pc_d;
      tail_instr_q <= tail_instr_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + (pop ? 32'd1 : 32'd0);
    perf_stall_d   = perf_stall_q + ((id_valid && !id_ready) ? 32'd1 : 32'd0);
    perf_flush_d   = perf_flush_q + (branch_taken ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
      perf_flush_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
      perf_flush_q   <= perf_flush_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
  assign perf_flush   = perf_flush_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a queue-based reference model,
// plus a directed 8-bit PC wrap check on a second instance.
module tb_if_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_req, imem_ack, br, id_valid, id_ready;
  logic [63:0] imem_addr, br_tgt, id_pc;
  logic [31:0] imem_rdata, id_instr;
  logic [6:0]  id_opcode;

  logic        s_reset, s_req, s_ack, s_valid, s_ready;
  logic [7:0]  s_addr, s_pc;
  logic [31:0] s_rdata, s_instr;
  logic [6:0]  s_opc;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall, perf_flush;
  logic [31:0] s_pf, s_ps, s_pfl;
`endif

  if_fetch_unit #(.PC_WIDTH(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .branch_taken(br),
    .branch_target(br_tgt), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instr(id_instr), .id_opcode(id_opcode)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
  );

  if_fetch_unit #(.PC_WIDTH(8), .RESET_PC(8'hFC)) u_small (
    .clk(clk), .reset(s_reset), .imem_req(s_req), .imem_addr(s_addr),
    .imem_ack(s_ack), .imem_rdata(s_rdata), .branch_taken(1'b0),
    .branch_target(8'h00), .id_valid(s_valid), .id_ready(s_ready),
    .id_pc(s_pc), .id_instr(s_instr), .id_opcode(s_opc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(s_pf), .perf_stall(s_ps), .perf_flush(s_pfl)
`endif
  );

  // Zero-wait memory whose data is the address itself.
  assign s_ack   = s_req;
  assign s_rdata = {24'h0, s_addr};

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  int          m_mode;      // 0 idle, 1 fetching, 2 draining wrong-path request
  logic [63:0] m_pc, m_kaddr;
  bit          m_after_rst;
  logic [31:0] m_pf, m_ps, m_pfl;

  bit          pend;
  int          lat;

  initial begin
    bit          rst_i, ack_i, br_i, rdy_i, e_req, acc, pop;
    logic [63:0] tgt_i;
    logic [31:0] rd_i;
    int          maxlat;

    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; br = 1'b0; br_tgt = '0; id_ready = 1'b0;
    s_reset = 1'b1; s_ready = 1'b1;
    m_mode = 0; m_pc = '0; m_kaddr = '0; m_after_rst = 1'b1;
    m_pf = '0; m_ps = '0; m_pfl = '0; pend = 1'b0; lat = 0;

    // 8-bit PC wrap: 0xFC then 0x00.
    repeat (2) @(posedge clk);
    #1 s_reset = 1'b0;
    @(posedge clk); #1;
    check("s_req0", s_req, 1);
    check("s_addr0", s_addr, 8'hFC);
    check("s_valid0", s_valid, 0);
    @(posedge clk); #1;
    check("s_valid1", s_valid, 1);
    check("s_pc1", s_pc, 8'hFC);
    check("s_instr1", s_instr, 32'hFC);
    check("s_addr1", s_addr, 8'h00);
    @(posedge clk); #1;
    check("s_pc2", s_pc, 8'h00);
    check("s_instr2", s_instr, 32'h00);
    check("s_opc2", s_opc, 7'h00);
    @(posedge clk); #1;
    s_ready = 1'b0;
`ifdef FETCH_PERF_EN
    check("s_perf_fetched", s_pf, 2);
`endif

    for (int n = 0; n < 1600; n++) begin
      @(posedge clk); #1;
      e_req = (m_mode == 2) || (m_mode == 1 && mq.size() != 2);
      if (n > 0) begin
        check("imem_req", imem_req, e_req);
        check("imem_addr", imem_addr, (m_mode == 2) ? m_kaddr : m_pc);
        check("id_valid", id_valid, mq.size() != 0);
        if (mq.size() != 0) begin
          check("id_pc", id_pc, mq[0].pc);
          check("id_instr", id_instr, mq[0].instr);
          check("id_opcode", id_opcode, mq[0].instr[6:0]);
        end else if (m_after_rst) begin
          check("id_pc_rst", id_pc, 0);
          check("id_instr_rst", id_instr, 32'h13);
          check("id_opcode_rst", id_opcode, 7'b0010011);
        end
`ifdef FETCH_PERF_EN
        check("perf_fetched", perf_fetched, m_pf);
        check("perf_stall", perf_stall, m_ps);
        check("perf_flush", perf_flush, m_pfl);
`endif
      end

      if (n < 2) begin
        rst_i = 1; rdy_i = 1; br_i = 0; maxlat = 0;
      end else if (n < 60) begin
        rst_i = 0; rdy_i = 1; br_i = 0; maxlat = 0;
      end else if (n < 200) begin
        rst_i = 0; rdy_i = !((n % 12) < 5); br_i = 0; maxlat = 1;
      end else begin
        rst_i = ($urandom_range(0, 99) == 0);
        rdy_i = ($urandom_range(0, 9) < 7);
        br_i  = ($urandom_range(0, 7) == 0);
        maxlat = 3;
      end
      tgt_i = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) tgt_i = tgt_i & 64'hFFF;
      rd_i = $urandom;

      if (!imem_req) pend = 1'b0;
      if (imem_req && !pend) begin
        pend = 1'b1;
        lat  = $urandom_range(0, maxlat);
      end
      ack_i = imem_req && pend && (lat == 0);
      if (ack_i) pend = 1'b0;
      else if (pend) lat--;
      if (rst_i) pend = 1'b0;

      rst = rst_i; imem_ack = ack_i; imem_rdata = rd_i; br = br_i; br_tgt = tgt_i; id_ready = rdy_i;

      if (rst_i) begin
        mq.delete();
        m_mode = 0; m_pc = '0; m_kaddr = '0; m_after_rst = 1'b1;
        m_pf = '0; m_ps = '0; m_pfl = '0;
      end else begin
        acc = ack_i && e_req;
        pop = (mq.size() != 0) && rdy_i;
        if (pop) m_pf++;
        if (mq.size() != 0 && !rdy_i) m_ps++;
        if (br_i) m_pfl++;
        if (br_i) begin
          mq.delete();
          if (m_mode == 2) m_mode = acc ? 1 : 2;
          else if (e_req && !acc) begin
            m_mode  = 2;
            m_kaddr = m_pc;
          end else m_mode = 1;
          m_pc = tgt_i & ~64'h3;
        end else if (m_mode == 0) begin
          m_mode = 1;
        end else if (m_mode == 2) begin
          if (acc) m_mode = 1;
        end else begin
          if (pop) void'(mq.pop_front());
          if (acc) begin
            mq.push_back('{pc: m_pc, instr: rd_i});
            m_pc = m_pc + 64'd4;
            m_after_rst = 1'b0;
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
